rom_loader_writer: RTL
======================

Name: rom_loader_writer

Overview:
- Sits between the iosys ROM byte stream (loading/loader_do/loader_do_valid) and the SDRAM loader port (port 1, toggle handshake).
- Packs each loaded byte into a big-endian 16-bit write with a byte enable, and buffers bytes in a small FIFO so SDRAM contention never drops data.
- Tracks ROM size and gates the Mega Drive core's run enable (md_on), which rises only after every byte has been committed to SDRAM.

Parameters:
ADDR_W, 22, byte-address width of the ROM region (4MB)
FIFO_DEPTH, 8, byte FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock (clk_sys domain)
reset  input  1  asynchronous, active-high reset
loading  input  3  iosys load state; nonzero = ROM load in progress
loader_do  input  8  ROM data byte
loader_do_valid  input  1  one-cycle strobe, loader_do valid
mem_addr  output  ADDR_W-1  word address to SDRAM port 1 (bits ADDR_W-1:1)
mem_din  output  16  write data, byte replicated in both halves
mem_be  output  2  byte enable: 2'b10 for even byte address, 2'b01 for odd
mem_req  output  1  toggle request; a new request is issued when mem_req==mem_ack
mem_ack  input  1  toggle acknowledge from SDRAM
rom_size  output  ADDR_W  byte count of the last completed load
md_on  output  1  core run enable
busy  output  1  high while FIFO is non-empty or a request is outstanding
overflow  output  1  sticky error: a byte was dropped or the address space was exceeded

Behaviour:
- Reset (async assert): state OFF, md_on=0, mem_req=0, mem_addr=0, mem_din=0, mem_be=0, rom_size=0, overflow=0, byte counter=0, FIFO empty. busy=0 once mem_ack=0.
- loading_r is a registered copy of (loading!=0). start = (loading!=0)&!loading_r; finish = (loading==0)&loading_r.
- States:
  - OFF: md_on=0.
  - LOAD: accepts bytes.
  - DRAIN: stops accepting bytes and empties the FIFO.
  - RUN: md_on=1.
- Transitions:
  - Any state on start -> LOAD. On that edge: counter=0, FIFO flushed, overflow cleared, md_on=0.
  - LOAD on finish -> DRAIN.
  - DRAIN when FIFO empty and mem_req==mem_ack -> RUN. On that edge: rom_size=counter, md_on=1.
  - start during DRAIN aborts the drain and goes to LOAD; rom_size is not updated.
- Byte accept (LOAD only):
  - loader_do_valid pushes {counter, loader_do} and increments counter.
  - loader_do_valid outside LOAD is ignored.
  - FIFO full at push: byte dropped, counter still increments, overflow=1.
  - Counter at all-ones: the final byte is stored, counter saturates, overflow=1; further bytes are dropped.
- Issue:
  - Condition: FIFO non-empty, mem_req==mem_ack, and state != OFF.
  - Action: pop the head entry and register mem_addr=addr[ADDR_W-1:1], mem_din={2{byte}}, mem_be=addr[0]?2'b01:2'b10, then toggle mem_req.
  - Outputs hold until the next issue.
  - Latency: byte captured at edge k; mem_req toggles at edge k+1 if idle.
  - Throughput: one byte per ack round-trip.
- Push and pop in the same cycle are legal; occupancy is unchanged.
- A flush on start does not cancel an outstanding request. New issues wait for that request's mem_ack toggle.
- loading changing value while remaining nonzero is not an edge.
- busy = FIFO non-empty | (mem_req != mem_ack).
- Reset asserted mid-load: everything returns to reset values. A toggle in flight is abandoned; SDRAM is required to be reset alongside this block.

Test Plan:
1. Load 4 bytes 0x12,0x34,0x56,0x78 with ack one cycle after each req, then drop loading. Expect: writes (addr 0, din 0x1212, be 10), (0, 0x3434, 01), (1, 0x5656, 10), (1, 0x7878, 01); rom_size=4; md_on=1 after the last ack.
2. Hold mem_ack for 20 cycles while 8 bytes arrive back-to-back. Expect: FIFO fills with no drop and overflow=0. A 9th byte before any ack is dropped and sets overflow=1. Counter reads 9 at finish.
3. Drop loading while 3 bytes are still queued. Expect: md_on stays 0 and busy=1 until the third ack, then md_on=1 on the next edge and rom_size equals the byte count.
4. Raise loading again during DRAIN with 2 bytes queued. Expect: FIFO flushed, the outstanding request still completes via its ack, counter=0, rom_size keeps its old value, md_on=0.
5. With ADDR_W=4, send 17 bytes. Expect: byte 16 (counter 15) is stored, byte 17 is dropped, overflow=1, rom_size=15 after finish.
6. Assert reset asynchronously mid-load with mem_req=1 pending. Expect: all outputs return to reset values immediately without a clk edge; md_on=0.

Source files
------------

// File: rtl/rom_loader_writer.sv
// rom_loader_writer
// Bridges the iosys ROM byte stream into SDRAM port 1. Each byte becomes a
// 16-bit big-endian write with a byte enable. Bytes are queued in a small
// FIFO so that SDRAM contention never loses data. The block tracks the size
// of the loaded ROM and raises md_on only once every byte is in SDRAM.
//
// Handshake (SDRAM port 1, toggle style): the port is idle when
// mem_req == mem_ack. A write is issued by registering mem_addr, mem_din and
// mem_be and inverting mem_req in the same cycle. Those outputs then hold
// until SDRAM inverts mem_ack to match, which completes the write and
// returns the port to idle. There is never more than one write outstanding.
module rom_loader_writer #(
    parameter int ADDR_W     = 22,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        loading,
    input  logic [7:0]        loader_do,
    input  logic              loader_do_valid,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic [1:0]        mem_be,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] rom_size,
    output logic              md_on,
    output logic              busy,
    output logic              overflow,
    output logic [1:0]        state_dbg
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // load edge detection
    logic loading_r;
    logic load_now;
    logic start;
    logic finish;

    // FSM-derived controls
    logic accept;
    logic issue_en;
    logic drain_done;

    // byte address counter
    logic [ADDR_W-1:0] counter;
    logic              saturated;
    logic              counter_max;

    // FIFO
    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [7:0]        data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_empty;
    logic              fifo_room;
    logic [ADDR_W-1:0] head_addr;
    logic [7:0]        head_data;

    // transfer controls
    logic req_idle;
    logic push_req;
    logic push;
    logic pop;

    assign load_now    = |loading;
    assign start       = load_now & ~loading_r;
    assign finish      = ~load_now & loading_r;

    assign req_idle    = (mem_req == mem_ack);
    assign fifo_empty  = (count == '0);
    assign counter_max = (counter == '1);
    assign head_addr   = addr_mem[rd_ptr];
    assign head_data   = data_mem[rd_ptr];

    // The start cycle flushes the FIFO, so nothing is popped from it then.
    assign pop       = issue_en & ~fifo_empty & req_idle & ~start;
    // A simultaneous pop frees the slot the incoming byte needs.
    assign fifo_room = (count != DEPTH_C) | pop;
    assign push_req  = accept & loader_do_valid;
    assign push      = push_req & ~saturated & fifo_room;

    assign busy      = ~fifo_empty | ~req_idle;
    assign state_dbg = state;

    // Registered copy of "a load is in progress" for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loading_r <= 1'b0;
        end else begin
            loading_r <= load_now;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a new load always wins, even over a drain in progress.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD:  if (finish) state_nxt = ST_DRAIN;
                ST_DRAIN: if (fifo_empty && req_idle) state_nxt = ST_RUN;
                default:  state_nxt = state;
            endcase
        end
    end

    // FSM outputs: byte acceptance, issue enable and the core run enable.
    always_comb begin
        accept     = 1'b0;
        issue_en   = 1'b0;
        md_on      = 1'b0;
        drain_done = 1'b0;
        case (state)
            ST_LOAD: begin
                accept   = 1'b1;
                issue_en = 1'b1;
            end
            ST_DRAIN: begin
                issue_en   = 1'b1;
                drain_done = (state_nxt == ST_RUN);
            end
            ST_RUN: begin
                issue_en = 1'b1;
                md_on    = 1'b1;
            end
            default: begin
                accept = 1'b0;
            end
        endcase
    end

    // Byte counter with saturation at the top of the address space, plus the
    // sticky overflow flag for dropped bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter   <= '0;
            saturated <= 1'b0;
            overflow  <= 1'b0;
        end else if (start) begin
            counter   <= '0;
            saturated <= 1'b0;
            overflow  <= 1'b0;
        end else if (push_req) begin
            // The byte at the last address is still stored; the counter then
            // stays put and every later byte of this load is dropped.
            if (!saturated) begin
                if (counter_max) begin
                    saturated <= 1'b1;
                end else begin
                    counter <= counter + 1'b1;
                end
            end
            if (saturated || counter_max || !fifo_room) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; a new load discards whatever is queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: byte address and data of each accepted byte.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= counter;
            data_mem[wr_ptr] <= loader_do;
        end
    end

    // Issue: pop the head entry into the port registers and toggle mem_req.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            mem_din  <= '0;
            mem_be   <= '0;
            mem_req  <= 1'b0;
        end else if (pop) begin
            mem_addr <= head_addr[ADDR_W-1:1];
            mem_din  <= {head_data, head_data};
            // Big-endian words: even byte address lands in the upper half.
            mem_be   <= head_addr[0] ? 2'b01 : 2'b10;
            mem_req  <= ~mem_req;
        end
    end

    // ROM size latches only when a load fully completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_size <= '0;
        end else if (drain_done) begin
            rom_size <= counter;
        end
    end

endmodule
